// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch,
// decode, execute, memory and writeback over the shared datapath.
//
// Ports:
//   clk, rst            core clock, async active-high reset
//   op, funct3,         instruction register fields
//   funct7b5
//   zero                ALU zero flag (branch resolution)
//   mem_ready           memory access completes in cycle it is 1
//   pc_write, adr_src,  datapath enables and mux selects
//   mem_write, ir_write,
//   result_src, alu_src_a, alu_src_b, alu_control,
//   reg_write, imm_src
//   state_o             current state (debug)
//   illegal_instr       trap flag
//
// Build option ILLEGAL_TRAP_EN: illegal instructions park the FSM in
// a sticky TRAP state. Without it they retire as a NOP.

module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic [3:0] state_o,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

`ifdef ILLEGAL_TRAP_EN
  localparam state_t S_ILL = S_TRAP;
`else
  localparam state_t S_ILL = S_FETCH;
`endif

  state_t state;
  state_t next;
  state_t dec_next;
  logic [3:0] alu_exec;
  logic [3:0] alu_br;
  logic       br_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= state_t'(RESET_STATE);
    else     state <= next;
  end

  assign state_o = state;

  // Branch funct3 010/011 do not exist and are rejected here so
  // BRANCH never sees them.
  always_comb begin
    dec_next = S_ILL;
    case (op)
      OP_LOAD,
      OP_STORE: dec_next = S_MEMADR;
      OP_R:     dec_next = S_EXECR;
      OP_I:     dec_next = S_EXECI;
      OP_BR:    dec_next = (funct3[2:1] == 2'b01)
                           ? S_ILL : S_BRANCH;
      OP_JAL:   dec_next = S_JAL;
      OP_JALR:  dec_next = S_JALR;
      OP_LUI:   dec_next = S_LUI;
      OP_AUIPC: dec_next = S_AUIPC;
      default:  dec_next = S_ILL;
    endcase
  end

  always_comb begin
    imm_src = 3'b000;
    unique case (1'b1)
      (op == OP_LOAD),
      (op == OP_JALR):  imm_src = 3'b101;
      (op == OP_I):     imm_src = (funct3[1:0] == 2'b01)
                                  ? 3'b110 : 3'b101;
      (op == OP_STORE): imm_src = 3'b100;
      (op == OP_BR):    imm_src = 3'b011;
      (op == OP_JAL):   imm_src = 3'b010;
      (op == OP_LUI),
      (op == OP_AUIPC): imm_src = 3'b001;
      default:          imm_src = 3'b000;
    endcase
  end

  // funct7b5 only selects sub for register ops; for immediates
  // bit 30 is part of the immediate except on srai.
  always_comb begin
    alu_exec = ALU_ADD;
    case (funct3)
      3'b000: alu_exec = (state == S_EXECR && funct7b5)
                         ? ALU_SUB : ALU_ADD;
      3'b001: alu_exec = ALU_SLL;
      3'b010: alu_exec = ALU_SLT;
      3'b011: alu_exec = ALU_SLTU;
      3'b100: alu_exec = ALU_XOR;
      3'b101: alu_exec = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_exec = ALU_OR;
      default: alu_exec = ALU_AND;
    endcase
  end

  always_comb begin
    alu_br = ALU_SUB;
    case (funct3[2:1])
      2'b10:   alu_br = ALU_SLT;
      2'b11:   alu_br = ALU_SLTU;
      default: alu_br = ALU_SUB;
    endcase
  end

  // beq/bge/bgeu take on zero, bne/blt/bltu on non-zero.
  always_comb begin
    case (funct3)
      3'b000,
      3'b101,
      3'b111:  br_take = zero;
      default: br_take = ~zero;
    endcase
  end

  always_comb begin
    next          = state;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = ALU_ADD;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    unique case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        next      = dec_next;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_exec;
        next        = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_exec;
        next        = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = alu_br;
        pc_write    = br_take;
        next        = S_FETCH;
      end
      S_JAL: begin
        pc_write = 1'b1;
        next     = S_LINK;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        next       = S_LINK;
      end
      S_LINK: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        reg_write  = 1'b1;
        next       = S_FETCH;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        reg_write  = 1'b1;
        next       = S_FETCH;
      end
      S_AUIPC: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        reg_write  = 1'b1;
        next       = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b1;
        next          = S_TRAP;
`else
        next          = S_FETCH;
`endif
      end
    endcase
    // FETCH drives the fetch enables from mem_ready, so hold every
    // architectural write off while reset is asserted.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a per-instruction
// state-path model and per-state output expectations.

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic       reg_write;
  logic [2:0] imm_src;
  logic [3:0] state_o;
  logic       illegal_instr;

  int tests = 0;
  int fails = 0;
  int mw_cnt = 0;
  int rw_cnt = 0;
  bit chk_en = 1'b0;
  logic [3:0] e_state = 4'd0;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] AU  = 7'b0010111;
  localparam logic [6:0] BAD = 7'b1111111;

  localparam logic [3:0] F3ALU [8] =
    '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control),
    .reg_write(reg_write), .imm_src(imm_src),
    .state_o(state_o), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] m_imm(input logic [6:0] o,
                                       input logic [2:0] f);
    if (o == LD || o == JR) return 3'b101;
    if (o == IT) return (f == 3'd1 || f == 3'd5) ? 3'b110 : 3'b101;
    if (o == ST) return 3'b100;
    if (o == BR) return 3'b011;
    if (o == JL) return 3'b010;
    if (o == LU || o == AU) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [3:0] m_alu(input logic [2:0] f,
                                       input logic f7,
                                       input bit is_r);
    if (f == 3'd0 && f7 && is_r) return 4'd1;
    if (f == 3'd5 && f7) return 4'd9;
    return F3ALU[f];
  endfunction

  // {pc_write,adr_src,mem_write,ir_write,result_src,a,b,alu,
  //  reg_write,imm_src,illegal_instr}
  function automatic logic [18:0] m_out(
      input logic [3:0] s, input logic [6:0] o,
      input logic [2:0] f, input logic f7,
      input logic z, input logic mr);
    logic pw, as, mw, iw, rw, il;
    logic [1:0] rs, a, b;
    logic [3:0] alu;
    {pw, as, mw, iw, rw, il} = '0;
    rs = 2'd0; a = 2'd0; b = 2'd0; alu = 4'd0;
    case (s)
      4'd0:  begin b = 2; rs = 2; iw = mr; pw = mr; end
      4'd1:  begin a = 1; b = 1; end
      4'd2:  begin a = 2; b = 1; end
      4'd3:  as = 1;
      4'd4:  begin rs = 1; rw = 1; end
      4'd5:  begin as = 1; mw = 1; end
      4'd6:  begin a = 2; alu = m_alu(f, f7, 1'b1); end
      4'd7:  begin a = 2; b = 1; alu = m_alu(f, f7, 1'b0); end
      4'd8:  rw = 1;
      4'd9: begin
        a = 2;
        alu = !f[2] ? 4'd1 : (f[1] ? 4'd6 : 4'd5);
        pw = (f == 0 || f == 5 || f == 7) ? z : !z;
      end
      4'd10: pw = 1;
      4'd11: begin a = 2; b = 1; rs = 2; pw = 1; end
      4'd12: begin a = 1; b = 2; rs = 2; rw = 1; end
      4'd13: begin a = 3; b = 1; rs = 2; rw = 1; end
      4'd14: begin a = 1; b = 1; rs = 2; rw = 1; end
      default: il = 1;
    endcase
    return {pw, as, mw, iw, rs, a, b, alu, rw, m_imm(o, f), il};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", {28'd0, state_o}, {28'd0, e_state});
      chk("outputs",
          {13'd0, pc_write, adr_src, mem_write, ir_write,
           result_src, alu_src_a, alu_src_b, alu_control,
           reg_write, imm_src, illegal_instr},
          {13'd0, m_out(e_state, op, funct3, funct7b5,
                        zero, mem_ready)});
      mw_cnt += int'(mem_write);
      rw_cnt += int'(reg_write);
    end
  end

  task automatic step_in(input logic [3:0] s, input logic mr);
    mem_ready = mr;
    e_state = s;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic step_out();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [3:0] s, input logic mr);
    step_in(s, mr);
    step_out();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_state", {28'd0, state_o}, 32'd0);
    chk("rst_en", {28'd0, pc_write, ir_write, reg_write, mem_write},
        32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", {27'd0, state_o, pc_write}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f,
                     input logic f7, input logic z,
                     input int fw, input int mw);
    op = o; funct3 = f; funct7b5 = f7; zero = z;
    mw_cnt = 0; rw_cnt = 0;
    repeat (fw) step(4'd0, 1'b0);
    step(4'd0, 1'b1);
    step(4'd1, 1'b0);
    if (o == LD) begin
      step(4'd2, 1'b0);
      repeat (mw) begin
        step_in(4'd3, 1'b0);
        chk("ld_imm", {29'd0, imm_src}, 32'h5);
        step_out();
      end
      step(4'd3, 1'b1);
      step_in(4'd4, 1'b0);
      chk("ld_rsrc", {30'd0, result_src}, 32'h1);
      step_out();
    end else if (o == ST) begin
      step(4'd2, 1'b0);
      repeat (mw) step(4'd5, 1'b0);
      step_in(4'd5, 1'b1);
      chk("st_imm", {29'd0, imm_src}, 32'h4);
      chk("st_adr", {31'd0, adr_src}, 32'h1);
      step_out();
      chk("st_mwcnt", mw_cnt, mw + 1);
    end else if (o == RT || o == IT) begin
      step_in(o == RT ? 4'd6 : 4'd7, 1'b0);
      if (o == RT && f == 3'd0 && f7)
        chk("sub_alu", {28'd0, alu_control}, 32'h1);
      step_out();
      step(4'd8, 1'b0);
      chk("rw_once", rw_cnt, 1);
    end else if (o == BR && f[2:1] != 2'b01) begin
      step_in(4'd9, 1'b0);
      if (f == 3'd0 && z) chk("beq_pc", {31'd0, pc_write}, 32'h1);
      if (f == 3'd1 && z) chk("bne_pc", {31'd0, pc_write}, 32'h0);
      if (f == 3'd4) chk("blt_alu", {28'd0, alu_control}, 32'h5);
      step_out();
    end else if (o == JL || o == JR) begin
      step(o == JL ? 4'd10 : 4'd11, 1'b0);
      step_in(4'd12, 1'b0);
      chk("link_rs", {30'd0, result_src, reg_write}, 32'h5);
      step_out();
    end else if (o == LU || o == AU) begin
      step(o == LU ? 4'd13 : 4'd14, 1'b0);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      repeat (2) step(4'd15, 1'b0);
      step_in(4'd15, 1'b1);
      chk("trap_flag", {31'd0, illegal_instr}, 32'h1);
      step_out();
      do_reset();
      chk("trap_clr", {31'd0, illegal_instr}, 32'h0);
`else
      step_in(4'd0, 1'b0);
      chk("nop_fetch", {27'd0, state_o, pc_write}, 32'h0);
      step_out();
      chk("nop_nowr", mw_cnt + rw_cnt, 0);
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b0;
    #2;
    do_reset();
    run(RT, 3'd0, 1'b1, 1'b0, 0, 0);
    run(RT, 3'd6, 1'b0, 1'b0, 2, 0);
    run(RT, 3'd5, 1'b1, 1'b0, 0, 0);
    run(IT, 3'd0, 1'b1, 1'b0, 0, 0);
    run(IT, 3'd5, 1'b1, 1'b0, 1, 0);
    run(IT, 3'd1, 1'b0, 1'b0, 0, 0);
    run(LD, 3'd2, 1'b0, 1'b0, 0, 3);
    run(ST, 3'd2, 1'b0, 1'b0, 0, 2);
    run(BR, 3'd0, 1'b0, 1'b1, 0, 0);
    run(BR, 3'd1, 1'b0, 1'b1, 0, 0);
    run(BR, 3'd4, 1'b0, 1'b0, 0, 0);
    run(BR, 3'd7, 1'b0, 1'b0, 0, 0);
    run(JL, 3'd0, 1'b0, 1'b0, 0, 0);
    run(JR, 3'd0, 1'b0, 1'b0, 0, 0);
    run(LU, 3'd0, 1'b0, 1'b0, 0, 0);
    run(AU, 3'd0, 1'b0, 1'b0, 0, 0);
    run(BAD, 3'd0, 1'b0, 1'b0, 0, 0);
    run(BR, 3'd2, 1'b0, 1'b0, 0, 0);
    // reset mid-store: mem_write must drop at once
    op = ST; funct3 = 3'd2;
    step(4'd0, 1'b1);
    step(4'd1, 1'b0);
    step(4'd2, 1'b0);
    step_in(4'd5, 1'b0);
    chk("mw_pre", {31'd0, mem_write}, 32'h1);
    do_reset();
    run(RT, 3'd4, 1'b0, 1'b0, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core. It sequences the shared ALU, memory port, register file and immediate generator across fetch, decode, execute, memory and writeback states.
- It drives the 3-bit immediate-type select consumed by the immediate generator, plus every datapath mux and write enable.
- It sits between the instruction register fields and the datapath; it holds no datapath state.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH). Must remain FETCH in product builds.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1.
- pc_write  out  1  PC load enable.
- adr_src  out  1  memory address select: 0=PC, 1=Result.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register and OldPC load.
- result_src  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=RD1, 11=zero.
- alu_src_b  out  2  ALU B select: 00=RD2, 01=Imm, 10=const 4.
- alu_control  out  4  ALU operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- reg_write  out  1  register file write enable.
- imm_src  out  3  immediate type.
- state_o  out  4  current state, for debug.
- illegal_instr  out  1  trap flag (optional feature only; tied 0 otherwise).

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LINK 12, LUI 13, AUIPC 14, TRAP 15. State is registered.
- Outputs are combinational from state and instruction fields. Every output is 0 unless listed for the current state.
- While rst=1: state=FETCH and pc_write, ir_write, reg_write, mem_write are forced 0.
- imm_src is decoded from op in all states:
  - 0000011, 1100111, and 0010011 with funct3≠001/101 → 101.
  - 0010011 with funct3=001/101 → 110.
  - 0100011 → 100.
  - 1100011 → 011.
  - 1101111 → 010.
  - 0110111, 0010111 → 001.
  - Any other op → 000.
- FETCH: adr_src=0, A=00, B=10, add, result_src=10. ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when 1.
- DECODE: A=01, B=01, add (precomputes branch/JAL target). Next state by op:
  - load/store → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other op → illegal handling
- MEMADR: A=10, B=01, add. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Wait for mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held high until mem_ready=1 → FETCH.
- EXECR: A=10, B=00. EXECI: A=10, B=01. Both → ALUWB.
- ALU decode in EXECR/EXECI by funct3:
  - 000: add; sub only if EXECR and funct7b5=1.
  - 001: sll. 010: slt. 011: sltu. 100: xor.
  - 101: srl, or sra if funct7b5=1.
  - 110: or. 111: and.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BRANCH: A=10, B=00, result_src=00. ALU op: sub for funct3 00x, slt for 10x, sltu for 11x. pc_write = zero for funct3 000/101/111, and !zero for 001/100/110. Funct3 010/011 are treated as illegal. → FETCH.
- JAL: result_src=00, pc_write=1 → LINK.
- JALR: A=10, B=01, add, result_src=10, pc_write=1 → LINK.
- LINK: A=01, B=10, add, result_src=10, reg_write=1 → FETCH.
- LUI: A=11, B=01, add, result_src=10, reg_write=1 → FETCH.
- AUIPC: A=01, B=01, add, result_src=10, reg_write=1 → FETCH.
- Reset asserted mid-access (e.g. in MEMWRITE): mem_write drops immediately (asynchronous reset); no partial writeback occurs.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal op/funct3 goes to TRAP. TRAP holds all enables 0, sets illegal_instr=1, and is sticky until rst.
- Undefined: an illegal instruction goes DECODE → FETCH with no writes (executes as a NOP); illegal_instr is tied 0.

Test Plan:
- Reset, then mem_ready=1, op=0110011, funct3=000, funct7b5=1 → state_o 0→1→6→8→0; alu_control=0001 in EXECR; reg_write=1 only in ALUWB.
- Load (op=0000011) with mem_ready=0 for 3 cycles in MEMREAD → state_o stays 3 for 3 cycles; then 4 with result_src=01; imm_src=101 throughout.
- Store (op=0100011), mem_ready=0 for 2 cycles → mem_write=1 for 3 cycles, adr_src=1, imm_src=100.
- beq (funct3=000) with zero=1 → pc_write=1 in BRANCH. bne with zero=1 → pc_write=0. blt → alu_control=0101.
- jalr (op=1100111) → states 1→11→12→0; pc_write in JALR; reg_write in LINK with result_src=10.
- op=1111111: macro undefined → DECODE→FETCH with no enables. Macro defined → state_o=15, illegal_instr=1 until rst.
